// File: rtl/sc_lane_rotator_pkg.sv
// Purpose : shared constants for the multi-lane pattern rotator.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sc_lane_rotator_pkg;

    // Per-lane direction encoding on SC_LANE_ROTATOR_DIR.
    localparam logic DIR_RIGHT = 1'b0;  // rotate toward bit 0
    localparam logic DIR_LEFT  = 1'b1;  // rotate toward the MSB

    // Default build parameters.
    localparam int DEF_DATAWIDTH_BUS = 8;
    localparam int DEF_LANES         = 4;
    localparam int DEF_DIVWIDTH      = 8;

endpackage : sc_lane_rotator_pkg

// File: rtl/sc_lane_rotator_lane.sv
// Purpose : one rotator lane: pattern register, step divider, optional bit probe.
// Latency : 1 cycle from load/tick edge to data_out/step_out (both registered).
// Backpressure: none; stepping is gated only by enable and a non-zero period.
//
// Ports:
//   SC_REGDD_CLOCK / SC_REGDD_RESET - clock, async active-high reset
//   enable    - global run; 0 freezes divider and pattern
//   load      - parallel-load strobe (wins over a step)
//   load_data - pattern to load
//   dir       - DIR_RIGHT / DIR_LEFT, only looked at on a tick
//   period    - step period in enabled cycles, 0 halts the lane
//   probe_col - (SC_LANE_ROTATOR_PROBE_EN only) bit index to observe
//   hit       - (SC_LANE_ROTATOR_PROBE_EN only) registered probed bit
//   data_out  - registered lane pattern
//   step_out  - one-cycle pulse alongside each newly rotated pattern
module sc_lane_rotator_lane
    import sc_lane_rotator_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
    parameter int DIVWIDTH      = DEF_DIVWIDTH
) (
    input  logic                     SC_REGDD_CLOCK,
    input  logic                     SC_REGDD_RESET,
    input  logic                     enable,
    input  logic                     load,
    input  logic [DATAWIDTH_BUS-1:0] load_data,
    input  logic                     dir,
    input  logic [DIVWIDTH-1:0]      period,
`ifdef SC_LANE_ROTATOR_PROBE_EN
    input  logic [$clog2(DATAWIDTH_BUS)-1:0] probe_col,
    output logic                     hit,
`endif
    output logic [DATAWIDTH_BUS-1:0] data_out,
    output logic                     step_out
);

    logic [DIVWIDTH-1:0]      cnt;
    logic                     run;
    logic                     tick;
    logic [DATAWIDTH_BUS-1:0] rot;
    logic [DATAWIDTH_BUS-1:0] pat_nxt;

    always_comb begin
        run  = enable && (period != '0);
        // ">=" rather than "==": if period shrinks below the running count,
        // the lane ticks on the very next enabled cycle and resynchronises.
        tick = run && (cnt >= (period - DIVWIDTH'(1)));
        if (dir == DIR_LEFT)
            rot = {data_out[DATAWIDTH_BUS-2:0], data_out[DATAWIDTH_BUS-1]};
        else
            rot = {data_out[0], data_out[DATAWIDTH_BUS-1:1]};
        if (load)
            pat_nxt = load_data;
        else if (tick)
            pat_nxt = rot;
        else
            pat_nxt = data_out;
    end

    always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
        if (SC_REGDD_RESET) begin
            data_out <= '0;
            cnt      <= '0;
            step_out <= 1'b0;
        end else begin
            data_out <= pat_nxt;
            step_out <= tick && !load;
            // A load restarts the divider so the next step is a full period out.
            if (load || tick)
                cnt <= '0;
            else if (run)
                cnt <= cnt + DIVWIDTH'(1);
        end
    end

`ifdef SC_LANE_ROTATOR_PROBE_EN
    logic hit_nxt;

    // Probe the next-state pattern so hit lines up with data_out.
    always_comb begin
        hit_nxt = 1'b0;
        if (32'(probe_col) < DATAWIDTH_BUS)
            hit_nxt = pat_nxt[probe_col];
    end

    always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
        if (SC_REGDD_RESET)
            hit <= 1'b0;
        else
            hit <= hit_nxt;
    end
`endif

endmodule : sc_lane_rotator_lane

// File: rtl/sc_lane_rotator.sv
// Purpose : LANES independent pattern rotators with per-lane period/direction.
// Latency : 1 cycle from load/tick edge to DATA_OUT/STEP_OUT (registered).
// Backpressure: none; ENABLE=0 freezes every lane, PERIOD=0 freezes one lane.
//
// Optional feature: define SC_LANE_ROTATOR_PROBE_EN to add the column probe
// (SC_LANE_ROTATOR_PROBE_COL in, SC_LANE_ROTATOR_HIT out).
//
// Ports:
//   SC_REGDD_CLOCK, SC_REGDD_RESET  - clock, async active-high reset
//   SC_LANE_ROTATOR_ENABLE          - global run
//   SC_LANE_ROTATOR_LOAD[i]         - lane i load strobe
//   SC_LANE_ROTATOR_LOAD_DATA       - lane i pattern at [i*DATAWIDTH_BUS +: DATAWIDTH_BUS]
//   SC_LANE_ROTATOR_DIR[i]          - lane i direction (0 right, 1 left)
//   SC_LANE_ROTATOR_PERIOD          - lane i period at [i*DIVWIDTH +: DIVWIDTH]
//   SC_LANE_ROTATOR_DATA_OUT        - registered lane patterns
//   SC_LANE_ROTATOR_STEP_OUT[i]     - lane i step pulse
module sc_lane_rotator
    import sc_lane_rotator_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
    parameter int LANES         = DEF_LANES,
    parameter int DIVWIDTH      = DEF_DIVWIDTH
) (
    input  logic                             SC_REGDD_CLOCK,
    input  logic                             SC_REGDD_RESET,
    input  logic                             SC_LANE_ROTATOR_ENABLE,
    input  logic [LANES-1:0]                 SC_LANE_ROTATOR_LOAD,
    input  logic [LANES*DATAWIDTH_BUS-1:0]   SC_LANE_ROTATOR_LOAD_DATA,
    input  logic [LANES-1:0]                 SC_LANE_ROTATOR_DIR,
    input  logic [LANES*DIVWIDTH-1:0]        SC_LANE_ROTATOR_PERIOD,
`ifdef SC_LANE_ROTATOR_PROBE_EN
    input  logic [$clog2(DATAWIDTH_BUS)-1:0] SC_LANE_ROTATOR_PROBE_COL,
    output logic [LANES-1:0]                 SC_LANE_ROTATOR_HIT,
`endif
    output logic [LANES*DATAWIDTH_BUS-1:0]   SC_LANE_ROTATOR_DATA_OUT,
    output logic [LANES-1:0]                 SC_LANE_ROTATOR_STEP_OUT
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sc_lane_rotator_lane #(
            .DATAWIDTH_BUS (DATAWIDTH_BUS),
            .DIVWIDTH      (DIVWIDTH)
        ) u_lane (
            .SC_REGDD_CLOCK (SC_REGDD_CLOCK),
            .SC_REGDD_RESET (SC_REGDD_RESET),
            .enable         (SC_LANE_ROTATOR_ENABLE),
            .load           (SC_LANE_ROTATOR_LOAD[i]),
            .load_data      (SC_LANE_ROTATOR_LOAD_DATA[i*DATAWIDTH_BUS +: DATAWIDTH_BUS]),
            .dir            (SC_LANE_ROTATOR_DIR[i]),
            .period         (SC_LANE_ROTATOR_PERIOD[i*DIVWIDTH +: DIVWIDTH]),
`ifdef SC_LANE_ROTATOR_PROBE_EN
            .probe_col      (SC_LANE_ROTATOR_PROBE_COL),
            .hit            (SC_LANE_ROTATOR_HIT[i]),
`endif
            .data_out       (SC_LANE_ROTATOR_DATA_OUT[i*DATAWIDTH_BUS +: DATAWIDTH_BUS]),
            .step_out       (SC_LANE_ROTATOR_STEP_OUT[i])
        );
    end

endmodule : sc_lane_rotator

// File: tb/tb_sc_lane_rotator.sv
// Purpose : directed self-checking bench for sc_lane_rotator (default 8x4x8 build).
// Latency : n/a.
// Backpressure: n/a.
module tb_sc_lane_rotator;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  ld;
    logic [31:0] ld_dat;
    logic [3:0]  dir;
    logic [31:0] per;
    logic [31:0] dout;
    logic [3:0]  step;
`ifdef SC_LANE_ROTATOR_PROBE_EN
    logic [2:0]  pcol;
    logic [3:0]  hit;
`endif

    int total = 0;
    int bad   = 0;

    sc_lane_rotator dut (
        .SC_REGDD_CLOCK            (clk),
        .SC_REGDD_RESET            (rst),
        .SC_LANE_ROTATOR_ENABLE    (en),
        .SC_LANE_ROTATOR_LOAD      (ld),
        .SC_LANE_ROTATOR_LOAD_DATA (ld_dat),
        .SC_LANE_ROTATOR_DIR       (dir),
        .SC_LANE_ROTATOR_PERIOD    (per),
`ifdef SC_LANE_ROTATOR_PROBE_EN
        .SC_LANE_ROTATOR_PROBE_COL (pcol),
        .SC_LANE_ROTATOR_HIT       (hit),
`endif
        .SC_LANE_ROTATOR_DATA_OUT  (dout),
        .SC_LANE_ROTATOR_STEP_OUT  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs of that edge are visible.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] d, input logic dr, input logic [7:0] p);
        ld_dat[i*8 +: 8] = d;
        dir[i]           = dr;
        per[i*8 +: 8]    = p;
    endtask

    function automatic logic [31:0] lane(input int i);
        return {24'h0, dout[i*8 +: 8]};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; ld = '0; ld_dat = '0; dir = '0; per = '0;
`ifdef SC_LANE_ROTATOR_PROBE_EN
        pcol = 3'd7;
`endif
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_step", {28'h0, step}, 32'h0);
        cyc(); cyc();
        rst = 1'b0;

        // Lane 0: 0x81 right, period 3. Lane 1: 0x01 left, period 2.
        en = 1'b1;
        set_lane(0, 8'h81, 1'b0, 8'd3);
        set_lane(1, 8'h01, 1'b1, 8'd2);
        ld = 4'b0011;
        cyc();
        ld = '0;
        chk("ld_l0", lane(0), 32'h81);
        chk("ld_step", {28'h0, step}, 32'h0);
        cyc();                                   // edge A
        chk("A_step", {28'h0, step}, 32'h0);
        cyc();                                   // edge B: lane1 ticks
        chk("B_l1", lane(1), 32'h02);
        chk("B_step", {28'h0, step}, 32'h2);
        chk("B_l0", lane(0), 32'h81);
        cyc();                                   // edge C: lane0 ticks
        chk("C_l0", lane(0), 32'hC0);
        chk("C_step", {28'h0, step}, 32'h1);
        cyc();                                   // edge D
        chk("D_l1", lane(1), 32'h04);
        chk("D_step", {28'h0, step}, 32'h2);
        cyc();                                   // edge E
        chk("E_step", {28'h0, step}, 32'h0);
        cyc();                                   // edge F: both tick
        chk("F_l0", lane(0), 32'h60);
        chk("F_l1", lane(1), 32'h08);
        chk("F_step", {28'h0, step}, 32'h3);

        // Lane 1 halted by period 0.
        per[15:8] = 8'd0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("halt_step1", {31'h0, step[1]}, 32'h0);
        end
        chk("halt_l1", lane(1), 32'h08);

        // Lane 0: left rotate, period 1 -> step every cycle.
        set_lane(0, 8'h81, 1'b1, 8'd1);
        ld = 4'b0001;
        cyc();
        ld = '0;
        chk("p1_ld", lane(0), 32'h81);
        cyc();
        chk("p1_a", lane(0), 32'h03);
        chk("p1_a_step", {31'h0, step[0]}, 32'h1);
        cyc();
        chk("p1_b", lane(0), 32'h06);
        chk("p1_b_step", {31'h0, step[0]}, 32'h1);

        // Period 4 with a 5-cycle enable gap after two counts.
        set_lane(0, 8'h81, 1'b0, 8'd4);
        ld = 4'b0001;
        cyc();
        ld = '0;
        cyc(); cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("gap_step", {28'h0, step}, 32'h0);
        end
        chk("gap_l0", lane(0), 32'h81);
        en = 1'b1;
        cyc();
        chk("reen1_step", {31'h0, step[0]}, 32'h0);
        chk("reen1_l0", lane(0), 32'h81);
        cyc();
        chk("reen2_step", {31'h0, step[0]}, 32'h1);
        chk("reen2_l0", lane(0), 32'hC0);

        // Load coinciding with a tick.
        set_lane(0, 8'h81, 1'b0, 8'd2);
        ld = 4'b0001;
        cyc();
        ld = '0;
        cyc();                                   // count 1
        ld_dat[7:0] = 8'h3C;
        ld = 4'b0001;
        cyc();                                   // would tick; load wins
        ld = '0;
        chk("ldtick_l0", lane(0), 32'h3C);
        chk("ldtick_step", {31'h0, step[0]}, 32'h0);
        cyc();
        chk("ldtick_c_step", {31'h0, step[0]}, 32'h0);
        cyc();
        chk("ldtick_d_l0", lane(0), 32'h1E);
        chk("ldtick_d_step", {31'h0, step[0]}, 32'h1);

        // Lower period below the running count.
        set_lane(0, 8'h81, 1'b0, 8'd8);
        ld = 4'b0001;
        cyc();
        ld = '0;
        for (int k = 0; k < 5; k++) cyc();
        chk("lower_pre", lane(0), 32'h81);
        per[7:0] = 8'd2;
        cyc();
        chk("lower_force_l0", lane(0), 32'hC0);
        chk("lower_force_step", {31'h0, step[0]}, 32'h1);
        cyc();
        chk("lower_n1", {31'h0, step[0]}, 32'h0);
        cyc();
        chk("lower_n2", {31'h0, step[0]}, 32'h1);

        // Reset between edges while a step pulse is showing.
        set_lane(0, 8'h81, 1'b0, 8'd3);
        ld = 4'b0001;
        cyc();
        ld = '0;
        cyc(); cyc(); cyc();
        chk("prerst_step", {31'h0, step[0]}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dout", dout, 32'h0);
        chk("midrst_step", {28'h0, step}, 32'h0);
        cyc();
        rst = 1'b0;
        ld = 4'b0001;
        cyc();
        ld = '0;
        cyc(); cyc();
        chk("postrst_2", {31'h0, step[0]}, 32'h0);
        cyc();
        chk("postrst_3_step", {31'h0, step[0]}, 32'h1);
        chk("postrst_3_l0", lane(0), 32'hC0);

`ifdef SC_LANE_ROTATOR_PROBE_EN
        // Probe column 7 on lane 1 rotating 0x01 right every cycle.
        set_lane(1, 8'h01, 1'b0, 8'd1);
        ld = 4'b0010;
        cyc();
        ld = '0;
        chk("hit_ld", {31'h0, hit[1]}, 32'h0);
        cyc();
        chk("hit_l1", lane(1), 32'h80);
        chk("hit_on", {31'h0, hit[1]}, 32'h1);
        cyc();
        chk("hit_off", {31'h0, hit[1]}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sc_lane_rotator

// File: doc/sc_lane_rotator.md
SC_LANE_ROTATOR -- requirements
Module: sc_lane_rotator

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8: bit width of each lane pattern; SHALL be at least 2.
REQ-002 Parameter LANES, default 4: number of independent lanes.
REQ-003 Parameter DIVWIDTH, default 8: width of each lane's step-period field and divider counter.
REQ-004 SC_REGDD_CLOCK  input  1: sole clock; all state SHALL update on its rising edge.
REQ-005 SC_REGDD_RESET  input  1: asynchronous, active-high reset.
REQ-006 SC_LANE_ROTATOR_ENABLE  input  1: global run; 0 freezes all stepping.
REQ-007 SC_LANE_ROTATOR_LOAD  input  LANES: per-lane parallel-load strobe.
REQ-008 SC_LANE_ROTATOR_LOAD_DATA  input  LANES*DATAWIDTH_BUS: per-lane load pattern, lane i at slice [i*W +: W].
REQ-009 SC_LANE_ROTATOR_DIR  input  LANES: per-lane direction; 0 = rotate right (toward bit 0), 1 = rotate left.
REQ-010 SC_LANE_ROTATOR_PERIOD  input  LANES*DIVWIDTH: per-lane step period in enabled cycles; 0 = lane halted.
REQ-011 SC_LANE_ROTATOR_DATA_OUT  output  LANES*DATAWIDTH_BUS: registered lane patterns.
REQ-012 SC_LANE_ROTATOR_STEP_OUT  output  LANES: registered one-cycle pulse per lane step.

Function
REQ-013 Each lane SHALL hold a pattern register and a DIVWIDTH-bit divider counter.
REQ-014 Per lane, on each clock edge, priority: LOAD > step > hold.
REQ-015 LOAD[i]=1 SHALL load the pattern from LOAD_DATA, clear the counter, and hold STEP_OUT[i] at 0, regardless of ENABLE.
REQ-016 When ENABLE=1 and PERIOD[i]!=0, a tick SHALL occur when counter >= PERIOD[i]-1: the counter clears and the lane steps; otherwise the counter increments.
REQ-017 Right step SHALL produce {p[0], p[W-1:1]}; left step SHALL produce {p[W-2:0], p[W-1]}.
REQ-018 DIR SHALL be sampled on the tick edge only; a DIR change between ticks affects only the next step.
REQ-019 STEP_OUT[i] SHALL be high for exactly the one cycle in which the newly rotated pattern first appears on DATA_OUT.
REQ-020 For PERIOD=N>0, steps SHALL occur every N enabled cycles, the first one N enabled cycles after reset or load.
REQ-021 PERIOD=1 SHALL step every enabled cycle, with STEP_OUT held continuously high.
REQ-022 When PERIOD is lowered below the current count, the >= comparison SHALL force a tick on the next enabled cycle; the counter never exceeds PERIOD-1 afterwards.
REQ-023 ENABLE=0 or PERIOD[i]=0 SHALL hold that lane's counter and pattern, with STEP_OUT[i]=0.
REQ-024 Lanes SHALL be fully independent; simultaneous ticks on any subset of lanes are permitted.

Reset
REQ-025 SC_REGDD_RESET=1 SHALL immediately clear, without a clock edge, all patterns, counters, STEP_OUT and optional probe outputs to 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after deassertion, counting restarts from 0.

Configuration
REQ-027 With macro SC_LANE_ROTATOR_PROBE_EN defined, the block SHALL add:
- input SC_LANE_ROTATOR_PROBE_COL, width $clog2(DATAWIDTH_BUS);
- output SC_LANE_ROTATOR_HIT, width LANES, registered.
REQ-028 With the macro defined, HIT[i] SHALL equal the bit at index PROBE_COL of the next-state pattern of lane i, so HIT is cycle-aligned with DATA_OUT.
REQ-029 With the macro defined, a PROBE_COL value >= DATAWIDTH_BUS SHALL give HIT=0.
REQ-030 Without the macro, the probe ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package sc_lane_rotator_pkg SHALL define the DIR_RIGHT=0 and DIR_LEFT=1 constants and the default parameter values.
REQ-032 Sub-module sc_lane_rotator_lane SHALL implement one lane (pattern, divider, step, optional probe), instantiated LANES times by a generate loop.

Verification
REQ-033 Lane 0: LOAD 8'b1000_0001, PERIOD=3, DIR=0, ENABLE=1 -> 3 cycles later DATA_OUT=8'b1100_0000 with STEP_OUT[0]=1 for one cycle; next step gives 8'b0110_0000.
REQ-034 Same load with DIR=1, PERIOD=1 -> consecutive cycles give 8'b0000_0011, then 8'b0000_0110, with STEP_OUT held high.
REQ-035 PERIOD=4; drop ENABLE after 2 counts for 5 cycles -> no step; first step occurs 2 enabled cycles after re-enable. PERIOD=0 -> pattern never changes.
REQ-036 LOAD asserted on a tick cycle -> LOAD_DATA is loaded, no rotation, STEP_OUT=0, and the next step is a full PERIOD later.
REQ-037 Assert reset between clock edges mid-count -> DATA_OUT=0 and STEP_OUT=0 immediately; first step is PERIOD enabled cycles after release and reload.
REQ-038 PROBE_EN build, PROBE_COL=7, lane 1 holds 8'b0000_0001, DIR=0, PERIOD=1 -> HIT[1]=1 on the cycle DATA_OUT shows 8'b1000_0000, and 0 on the following cycle.
